// File: rtl/cache_control.sv
// Miss/hit sequencer for the 2-way L1 cache datapath: replies to CPU hits in the same cycle, write-back of a dirty victim then line fill on a miss.
// All outputs are combinational from state and inputs; physical memory stalls are absorbed by holding state until pmem_resp.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 pmem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 ishit0_out,
    input  logic                 ishit1_out,
    input  logic                 dirtyarr0_out,
    input  logic                 dirtyarr1_out,
    input  logic                 lru_out,
    output logic                 datainmux_sel,
    output logic [1:0]           addressmux_sel,
    output logic                 dataarr0_write,
    output logic                 dataarr1_write,
    output logic                 tag0_write,
    output logic                 tag1_write,
    output logic                 valid0_write,
    output logic                 valid1_write,
    output logic                 dirtyarr0_write,
    output logic                 dirtyarr1_write,
    output logic                 dirty_datain,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        HIT_CHECK  = 2'b00,
        WRITE_BACK = 2'b01,
        ALLOCATE   = 2'b10
    } state_t;

    state_t state;
    state_t state_next;
    logic   victim;

    logic req;
    logic hit;
    logic is_write;
    logic victim_dirty;

    assign req          = mem_read | mem_write;
    assign hit          = ishit0_out | ishit1_out;
    assign is_write     = mem_write;
    assign victim_dirty = lru_out ? dirtyarr1_out : dirtyarr0_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HIT_CHECK;
            victim     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_next;
            if (state == HIT_CHECK && req && hit && hit_count != '1)
                hit_count <= hit_count + CNT_WIDTH'(1);
            // Victim is captured once, at the miss decision, so LRU updates during the miss cannot move it.
            if (state == HIT_CHECK && req && !hit) begin
                victim <= lru_out;
                if (miss_count != '1)
                    miss_count <= miss_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next      = state;
        mem_resp        = 1'b0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        datainmux_sel   = 1'b0;
        addressmux_sel  = 2'b00;
        dataarr0_write  = 1'b0;
        dataarr1_write  = 1'b0;
        tag0_write      = 1'b0;
        tag1_write      = 1'b0;
        valid0_write    = 1'b0;
        valid1_write    = 1'b0;
        dirtyarr0_write = 1'b0;
        dirtyarr1_write = 1'b0;
        dirty_datain    = 1'b0;
        case (state)
            HIT_CHECK: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        if (is_write) begin
                            datainmux_sel = 1'b1;
                            dirty_datain  = 1'b1;
                            if (ishit0_out) begin
                                dataarr0_write  = 1'b1;
                                dirtyarr0_write = 1'b1;
                            end else begin
                                dataarr1_write  = 1'b1;
                                dirtyarr1_write = 1'b1;
                            end
                        end
                    end else begin
                        state_next = victim_dirty ? WRITE_BACK : ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                pmem_write     = 1'b1;
                addressmux_sel = victim ? 2'b10 : 2'b01;
                if (pmem_resp)
                    state_next = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    // Fresh line from memory is clean; dirty_datain stays 0.
                    if (victim) begin
                        dataarr1_write  = 1'b1;
                        tag1_write      = 1'b1;
                        valid1_write    = 1'b1;
                        dirtyarr1_write = 1'b1;
                    end else begin
                        dataarr0_write  = 1'b1;
                        tag0_write      = 1'b1;
                        valid0_write    = 1'b1;
                        dirtyarr0_write = 1'b1;
                    end
                    state_next = HIT_CHECK;
                end
            end
            default: state_next = HIT_CHECK;
        endcase
    end

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: directed per-cycle vectors push expected outputs, a negedge monitor pops and compares.
module tb_cache_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, mem_read, mem_write, pmem_resp;
    logic ishit0_out, ishit1_out, dirtyarr0_out, dirtyarr1_out, lru_out;

    logic        mem_resp, pmem_read, pmem_write, datainmux_sel;
    logic [1:0]  addressmux_sel;
    logic        dataarr0_write, dataarr1_write, tag0_write, tag1_write;
    logic        valid0_write, valid1_write, dirtyarr0_write, dirtyarr1_write, dirty_datain;
    logic [15:0] hit_count, miss_count;

    logic        s_mem_resp, s_pmem_read, s_pmem_write, s_datainmux_sel;
    logic [1:0]  s_addressmux_sel;
    logic        s_dataarr0_write, s_dataarr1_write, s_tag0_write, s_tag1_write;
    logic        s_valid0_write, s_valid1_write, s_dirtyarr0_write, s_dirtyarr1_write, s_dirty_datain;
    logic [1:0]  s_hit_count, s_miss_count;

    cache_control #(.CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .ishit0_out(ishit0_out), .ishit1_out(ishit1_out),
        .dirtyarr0_out(dirtyarr0_out), .dirtyarr1_out(dirtyarr1_out), .lru_out(lru_out),
        .datainmux_sel(datainmux_sel), .addressmux_sel(addressmux_sel),
        .dataarr0_write(dataarr0_write), .dataarr1_write(dataarr1_write),
        .tag0_write(tag0_write), .tag1_write(tag1_write),
        .valid0_write(valid0_write), .valid1_write(valid1_write),
        .dirtyarr0_write(dirtyarr0_write), .dirtyarr1_write(dirtyarr1_write),
        .dirty_datain(dirty_datain), .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_control #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(s_mem_resp), .pmem_resp(pmem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .ishit0_out(ishit0_out), .ishit1_out(ishit1_out),
        .dirtyarr0_out(dirtyarr0_out), .dirtyarr1_out(dirtyarr1_out), .lru_out(lru_out),
        .datainmux_sel(s_datainmux_sel), .addressmux_sel(s_addressmux_sel),
        .dataarr0_write(s_dataarr0_write), .dataarr1_write(s_dataarr1_write),
        .tag0_write(s_tag0_write), .tag1_write(s_tag1_write),
        .valid0_write(s_valid0_write), .valid1_write(s_valid1_write),
        .dirtyarr0_write(s_dirtyarr0_write), .dirtyarr1_write(s_dirtyarr1_write),
        .dirty_datain(s_dirty_datain), .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    // Expected-output bit positions in the packed observation vector.
    localparam logic [14:0] RSP = 15'h4000, PRD = 15'h2000, PWR = 15'h1000, DSL = 15'h0800;
    localparam logic [14:0] A01 = 15'h0200, A10 = 15'h0400;
    localparam logic [14:0] D0 = 15'h0100, D1 = 15'h0080, T0 = 15'h0040, T1 = 15'h0020;
    localparam logic [14:0] V0 = 15'h0010, V1 = 15'h0008, Y0 = 15'h0004, Y1 = 15'h0002, DIN = 15'h0001;

    typedef struct {
        string       name;
        logic [14:0] outs;
        logic [15:0] hc;
        logic [15:0] mc;
        logic [1:0]  shc;
        logic [1:0]  smc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [15:0] m_hc = 0, m_mc = 0;
    logic [1:0]  m_shc = 0, m_smc = 0;

    logic [14:0] obs;
    assign obs = {mem_resp, pmem_read, pmem_write, datainmux_sel, addressmux_sel,
                  dataarr0_write, dataarr1_write, tag0_write, tag1_write,
                  valid0_write, valid1_write, dirtyarr0_write, dirtyarr1_write, dirty_datain};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e.outs) begin
                n_bad++;
                $display("FAIL %s outs: got %h want %h", e.name, obs, e.outs);
            end
            n_cmp++;
            if (hit_count !== e.hc) begin
                n_bad++;
                $display("FAIL %s hit_count: got %0d want %0d", e.name, hit_count, e.hc);
            end
            n_cmp++;
            if (miss_count !== e.mc) begin
                n_bad++;
                $display("FAIL %s miss_count: got %0d want %0d", e.name, miss_count, e.mc);
            end
            n_cmp++;
            if (s_hit_count !== e.shc) begin
                n_bad++;
                $display("FAIL %s sat_hit_count: got %0d want %0d", e.name, s_hit_count, e.shc);
            end
            n_cmp++;
            if (s_miss_count !== e.smc) begin
                n_bad++;
                $display("FAIL %s sat_miss_count: got %0d want %0d", e.name, s_miss_count, e.smc);
            end
        end
    end

    // One cycle: drive inputs, queue the expected outputs for this cycle, then apply counter effects of the edge.
    task automatic step(input string nm, input bit rst, rd, wr, h0, h1, d0, d1, lru, presp,
                        input logic [14:0] exp_outs, input bit hi, mi, chk);
        exp_t e;
        reset = rst; mem_read = rd; mem_write = wr;
        ishit0_out = h0; ishit1_out = h1; dirtyarr0_out = d0; dirtyarr1_out = d1;
        lru_out = lru; pmem_resp = presp;
        if (chk) begin
            e.name = nm; e.outs = exp_outs;
            e.hc = m_hc; e.mc = m_mc; e.shc = m_shc; e.smc = m_smc;
            sb.push_back(e);
        end
        if (rst) begin
            m_hc = 0; m_mc = 0; m_shc = 0; m_smc = 0;
        end else begin
            if (hi) begin
                m_hc = m_hc + 16'd1;
                if (m_shc != 2'd3) m_shc = m_shc + 2'd1;
            end
            if (mi) begin
                m_mc = m_mc + 16'd1;
                if (m_smc != 2'd3) m_smc = m_smc + 2'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //    name          rst rd wr h0 h1 d0 d1 lru pr  expected outputs          hi mi chk
        step("reset0",      1,  0, 0, 0, 0, 0, 0, 0,  0,  15'h0,                    0, 0, 0);
        step("reset1",      1,  0, 0, 0, 0, 0, 0, 0,  0,  15'h0,                    0, 0, 1);
        step("idle",        0,  0, 0, 0, 0, 0, 0, 0,  0,  15'h0,                    0, 0, 1);
        step("rd_hit1",     0,  1, 0, 0, 1, 0, 0, 0,  0,  RSP,                      1, 0, 1);
        step("wr_hit0",     0,  0, 1, 1, 0, 0, 0, 0,  0,  RSP|DSL|D0|Y0|DIN,        1, 0, 1);
        step("rdwr_hit1",   0,  1, 1, 0, 1, 0, 0, 0,  0,  RSP|DSL|D1|Y1|DIN,        1, 0, 1);
        step("presp_idle",  0,  0, 0, 0, 0, 0, 0, 0,  1,  15'h0,                    0, 0, 1);
        step("clean_miss",  0,  1, 0, 0, 0, 1, 0, 1,  0,  15'h0,                    0, 1, 1);
        step("alloc_w1",    0,  1, 0, 0, 0, 1, 0, 1,  0,  PRD,                      0, 0, 1);
        step("alloc_w2",    0,  1, 0, 0, 0, 1, 0, 1,  0,  PRD,                      0, 0, 1);
        step("alloc_fill1", 0,  1, 0, 0, 0, 1, 0, 1,  1,  PRD|D1|T1|V1|Y1,          0, 0, 1);
        step("rehit1",      0,  1, 0, 0, 1, 0, 0, 0,  0,  RSP,                      1, 0, 1);
        step("dirty_miss0", 0,  0, 1, 0, 0, 1, 0, 0,  0,  15'h0,                    0, 1, 1);
        step("wb0_wait",    0,  0, 1, 0, 0, 1, 0, 1,  0,  PWR|A01,                  0, 0, 1);
        step("wb0_resp",    0,  0, 1, 0, 0, 1, 0, 1,  1,  PWR|A01,                  0, 0, 1);
        step("alloc0_wait", 0,  0, 1, 0, 0, 0, 0, 1,  0,  PRD,                      0, 0, 1);
        step("alloc_fill0", 0,  0, 1, 0, 0, 0, 0, 1,  1,  PRD|D0|T0|V0|Y0,          0, 0, 1);
        step("wr_rehit0",   0,  0, 1, 1, 0, 0, 0, 1,  0,  RSP|DSL|D0|Y0|DIN,        1, 0, 1);
        step("dirty_miss1", 0,  1, 0, 0, 0, 0, 1, 1,  0,  15'h0,                    0, 1, 1);
        step("wb1_wait",    0,  1, 0, 0, 0, 0, 1, 0,  0,  PWR|A10,                  0, 0, 1);
        step("wb1_reset",   1,  1, 0, 0, 0, 0, 1, 0,  0,  PWR|A10,                  0, 0, 1);
        step("post_reset",  0,  0, 0, 0, 0, 0, 0, 0,  0,  15'h0,                    0, 0, 1);
        step("drop_miss",   0,  1, 0, 0, 0, 0, 0, 0,  0,  15'h0,                    0, 1, 1);
        step("drop_fill0",  0,  0, 0, 0, 0, 0, 0, 0,  1,  PRD|D0|T0|V0|Y0,          0, 0, 1);
        step("drop_idle",   0,  0, 0, 0, 0, 0, 0, 0,  0,  15'h0,                    0, 0, 1);
        for (int i = 0; i < 5; i++)
            step("sat_rd_hit", 0, 1, 0, 1, 0, 0, 0, 0, 0, RSP,                      1, 0, 1);
        step("final_idle",  0,  0, 0, 0, 0, 0, 0, 0,  0,  15'h0,                    0, 0, 1);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Controller FSM for the 2-way set-associative L1 cache datapath; sits directly beside that datapath.
- Consumes its hit, dirty and LRU status and drives its mux selects and array write enables.
- Handshakes with the CPU (mem_read/mem_write/mem_resp) and with physical memory (pmem_read/pmem_write/pmem_resp).
- Latches the miss victim way and keeps saturating hit/miss counters.

Parameters:
CNT_WIDTH, 16, width of the hit_count and miss_count performance counters.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
mem_read  input  1  CPU read request, held until mem_resp
mem_write  input  1  CPU write request, held until mem_resp
mem_resp  output  1  CPU request complete
pmem_resp  input  1  physical memory transfer complete
pmem_read  output  1  physical memory line read request
pmem_write  output  1  physical memory line write request
ishit0_out  input  1  way0 valid tag match
ishit1_out  input  1  way1 valid tag match
dirtyarr0_out  input  1  way0 dirty bit at current index
dirtyarr1_out  input  1  way1 dirty bit at current index
lru_out  input  1  LRU way at current index (0=way0, 1=way1)
datainmux_sel  output  1  0=pmem_rdata, 1=CPU-merged block
addressmux_sel  output  2  00=CPU address, 01=way0 tag addr, 10=way1 tag addr
dataarr0_write / dataarr1_write  output  1 each  data array write enables
tag0_write / tag1_write  output  1 each  tag array write enables
valid0_write / valid1_write  output  1 each  valid array write enables
dirtyarr0_write / dirtyarr1_write  output  1 each  dirty array write enables
dirty_datain  output  1  value written into the dirty array
hit_count  output  CNT_WIDTH  completed hits, saturating
miss_count  output  CNT_WIDTH  misses detected, saturating

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high. All state updates on the rising edge of clk.
- Reset: state=HIT_CHECK, victim=0, hit_count=0, miss_count=0. All outputs are combinational from state and inputs. With no request in HIT_CHECK, every output is 0 (addressmux_sel=00).
- Request: req = mem_read | mem_write. If both are high, the request is treated as a write.
- HIT_CHECK:
  - req & (ishit0_out | ishit1_out): mem_resp=1 in the same cycle; hit_count+1; stay in HIT_CHECK.
  - Write hit on way w: datainmux_sel=1, dataarrW_write=1, dirtyarrW_write=1, dirty_datain=1.
  - Read hit: no array writes.
  - req & no hit: miss_count+1; victim<=lru_out.
  - Miss, next state: WRITE_BACK if the victim's dirty bit is 1 (selected by lru_out this cycle), else ALLOCATE. mem_resp=0.
- WRITE_BACK:
  - pmem_write=1; addressmux_sel=01 if victim=0, else 10.
  - Hold all outputs until pmem_resp=1, then go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, addressmux_sel=00, datainmux_sel=0.
  - On pmem_resp=1, assert for the victim way, for one cycle only: dataarrV_write, tagV_write, validV_write, dirtyarrV_write with dirty_datain=0. Then go to HIT_CHECK.
  - The next cycle re-evaluates the request and hits. A write completes as a write hit.
- Victim register: changes only on the HIT_CHECK miss decision. It is immune to LRU updates during the miss.
- pmem_resp in HIT_CHECK is ignored.
- CPU request deasserted mid-miss: the sequence still completes; HIT_CHECK then idles.
- Counters saturate at all-ones; no wrap.
- reset in any state: HIT_CHECK on the next edge; pmem_read/pmem_write are low from that cycle on.
- mem_resp is never asserted outside HIT_CHECK.

Test Plan:
- Read hit: reset, mem_read=1, ishit1_out=1 -> same-cycle mem_resp=1, no write enables, hit_count=1.
- Write hit way0: mem_write=1, ishit0_out=1 -> datainmux_sel=1, dataarr0_write=1, dirtyarr0_write=1, dirty_datain=1, mem_resp=1.
- Clean miss: mem_read=1, no hit, lru_out=1, dirtyarr1_out=0 -> ALLOCATE, pmem_read=1 for 3 cycles until pmem_resp. Then dataarr1/tag1/valid1/dirtyarr1_write=1 for one cycle; next cycle (ishit1_out=1) mem_resp=1; miss_count=1.
- Dirty miss: lru_out=0, dirtyarr0_out=1 -> pmem_write=1, addressmux_sel=01 until pmem_resp. Then ALLOCATE; lru_out flipped to 1 mid-miss still writes way0.
- Reset mid-WRITE_BACK: reset=1 one cycle -> pmem_write=0 next cycle, counters 0, state HIT_CHECK.
- Saturation: CNT_WIDTH=2, five read hits -> hit_count=3.
